// File: rtl/xbar_pkg.sv
// Shared definitions for the AXI crossbar: arbiter state encoding and
// the width helper used to size master-index and slave-destination fields.
package xbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // ceil(log2(n)), but never less than 1 so single-entry vectors stay legal
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/xbar_slave_arbiter_picker.sv
// Combinational first-set search over a request vector.  With rr_en the
// search starts at ptr and wraps from N-1 back to 0; without it the search
// starts at index 0, giving a fixed lowest-index-wins priority.
module rr_priority_picker
    import xbar_pkg::*;
#(
    parameter int N = 4,
    localparam int MW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    input  logic          rr_en,
    output logic          any,
    output logic [MW-1:0] idx
);

    int   cand;
    logic found;

    // Walk the N candidate positions in priority order, keep the first hit
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = rr_en ? ((int'(ptr) + k) % N) : k;
            if (!found && req[cand]) begin
                idx   = MW'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port burst arbiter.  Picks one master whose FIFO head targets
// this slave, holds the grant until the last beat of that burst is popped,
// then returns to IDLE for one arbitration cycle before the next grant.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int MASTERS  = 4,
    parameter int SLAVES   = 4,
    parameter int SLAVE_ID = 0,
    parameter int RR_MODE  = 1,
    localparam int MW = clog2_min1(MASTERS),
    localparam int DW = clog2_min1(SLAVES)
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [MASTERS-1:0]           master_fifo_empty,
    input  logic [MASTERS-1:0][DW-1:0]   master_slave_dest,
    input  logic [MASTERS-1:0]           master_beat_last,
    input  logic                         slave_ready,
    output logic                         grant_valid,
    output logic [MW-1:0]                grant_master_number,
    output logic [MASTERS-1:0]           grant_onehot,
    output logic [MASTERS-1:0]           master_pop
);

    arb_state_e          state;
    logic [MW-1:0]       owner;
    logic [MW-1:0]       rr_ptr;
    logic [MASTERS-1:0]  req;
    logic                req_any;
    logic [MW-1:0]       win_idx;
    logic                pop_ok;
    logic                last_pop;

    // A master requests when its FIFO head is present and addressed to us
    always_comb begin
        req = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == DW'(SLAVE_ID));
        end
    end

    rr_priority_picker #(
        .N (MASTERS)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .rr_en (RR_MODE != 0),
        .any   (req_any),
        .idx   (win_idx)
    );

    // The owner pops whenever the slave accepts and its FIFO has a beat
    always_comb begin
        pop_ok   = (state == BUSY) & slave_ready & ~master_fifo_empty[owner];
        last_pop = pop_ok & master_beat_last[owner];
        master_pop = '0;
        if (pop_ok) begin
            master_pop[owner] = 1'b1;
        end
    end

    // Grant outputs decode purely from registered state and owner
    always_comb begin
        grant_valid         = (state == BUSY);
        grant_master_number = owner;
        grant_onehot        = '0;
        if (state == BUSY) begin
            grant_onehot[owner] = 1'b1;
        end
    end

    // Arbitrate in IDLE, hold through the burst in BUSY, rotate on release
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner <= win_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_pop) begin
                        state <= IDLE;
                        if (RR_MODE != 0) begin
                            rr_ptr <= (owner == MW'(MASTERS - 1)) ? '0 : owner + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Testbench for xbar_slave_arbiter: a round-robin and a fixed-priority
// instance share one set of inputs; a queue-free burst-level reference
// model tracks each, plus a directed vector table and corner sequences.
module tb_xbar_slave_arbiter;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [3:0]      master_fifo_empty;
    logic [3:0][1:0] master_slave_dest;
    logic [3:0]      master_beat_last;
    logic            slave_ready;

    logic            rr_valid, fx_valid;
    logic [1:0]      rr_num, fx_num;
    logic [3:0]      rr_onehot, fx_onehot;
    logic [3:0]      rr_pop, fx_pop;

    always #5 ACLK = ~ACLK;

    xbar_slave_arbiter #(.MASTERS(4), .SLAVES(4), .SLAVE_ID(0), .RR_MODE(1)) dut_rr (
        .ACLK                (ACLK),
        .ARESET              (ARESET),
        .master_fifo_empty   (master_fifo_empty),
        .master_slave_dest   (master_slave_dest),
        .master_beat_last    (master_beat_last),
        .slave_ready         (slave_ready),
        .grant_valid         (rr_valid),
        .grant_master_number (rr_num),
        .grant_onehot        (rr_onehot),
        .master_pop          (rr_pop)
    );

    xbar_slave_arbiter #(.MASTERS(4), .SLAVES(4), .SLAVE_ID(0), .RR_MODE(0)) dut_fx (
        .ACLK                (ACLK),
        .ARESET              (ARESET),
        .master_fifo_empty   (master_fifo_empty),
        .master_slave_dest   (master_slave_dest),
        .master_beat_last    (master_beat_last),
        .slave_ready         (slave_ready),
        .grant_valid         (fx_valid),
        .grant_master_number (fx_num),
        .grant_onehot        (fx_onehot),
        .master_pop          (fx_pop)
    );

    typedef struct {
        logic       rst;
        logic [3:0] empty;
        logic [7:0] dest;
        logic [3:0] last;
        logic       ready;
        logic       valid;
        logic [1:0] num;
        logic [3:0] onehot;
        logic [3:0] pop;
    } vec_t;

    vec_t vecs[12];

    int cmp_count  = 0;
    int fail_count = 0;

    // Reference model per instance (0 = round-robin, 1 = fixed):
    // busy flag, owning master, round-robin start index
    int mb[2];
    int mo[2];
    int mp[2];
    int exp_pop_s[2];

    // Stimulus-side FIFO emulation: beats queued, burst length, beat position, destination
    int fcnt[4];
    int blen[4];
    int bpos[4];
    int fdest[4];
    int follow;
    logic tb_rst;
    logic tb_ready;

    function automatic vec_t mk(input logic rst, input logic [3:0] e, input logic [7:0] d,
                                input logic [3:0] l, input logic r, input logic v,
                                input logic [1:0] n, input logic [3:0] oh, input logic [3:0] p);
        vec_t x;
        x.rst = rst; x.empty = e; x.dest = d; x.last = l; x.ready = r;
        x.valid = v; x.num = n; x.onehot = oh; x.pop = p;
        return x;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [3:0] e, input logic [7:0] d,
                                 input logic [3:0] l, input logic r);
        ARESET            = rst;
        master_fifo_empty = e;
        master_slave_dest = d;
        master_beat_last  = l;
        slave_ready       = r;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmp_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit requests(input int j);
        return !master_fifo_empty[j] && (master_slave_dest[j] == 2'd0);
    endfunction

    // Burst-level behaviour: grab a requester when free, free up on a popped last beat
    task automatic model_update(input int m);
        int first;
        int j;
        if (ARESET) begin
            mb[m] = 0; mo[m] = 0; mp[m] = 0;
        end else if (mb[m] == 0) begin
            first = -1;
            for (int k = 0; k < 4; k++) begin
                j = (m == 0) ? (mp[m] + k) % 4 : k;
                if (first < 0 && requests(j)) first = j;
            end
            if (first >= 0) begin
                mb[m] = 1;
                mo[m] = first;
            end
        end else if (slave_ready && !master_fifo_empty[mo[m]] && master_beat_last[mo[m]]) begin
            mb[m] = 0;
            if (m == 0) mp[m] = (mo[m] + 1) % 4;
        end
    endtask

    task automatic check_models();
        int ev, en, eoh, ep;
        for (int m = 0; m < 2; m++) begin
            ev  = mb[m];
            en  = mo[m];
            eoh = mb[m] ? (1 << mo[m]) : 0;
            ep  = (mb[m] && slave_ready && !master_fifo_empty[mo[m]]) ? (1 << mo[m]) : 0;
            exp_pop_s[m] = ep;
            if (m == 0) begin
                checkOutput("rr_valid",  int'(rr_valid),  ev);
                checkOutput("rr_master", int'(rr_num),    en);
                checkOutput("rr_onehot", int'(rr_onehot), eoh);
                checkOutput("rr_pop",    int'(rr_pop),    ep);
            end else begin
                checkOutput("fx_valid",  int'(fx_valid),  ev);
                checkOutput("fx_master", int'(fx_num),    en);
                checkOutput("fx_onehot", int'(fx_onehot), eoh);
                checkOutput("fx_pop",    int'(fx_pop),    ep);
            end
        end
    endtask

    task automatic begin_cycle();
        logic [3:0] e, l;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            e[i]         = (fcnt[i] == 0);
            l[i]         = (bpos[i] == blen[i] - 1);
            d[2*i +: 2]  = 2'(fdest[i]);
        end
        applyStimulus(tb_rst, e, d, l, tb_ready);
        #1;
        check_models();
    endtask

    task automatic end_cycle();
        int p;
        p = exp_pop_s[follow];
        @(posedge ACLK);
        model_update(0);
        model_update(1);
        for (int i = 0; i < 4; i++) begin
            if (p[i] && fcnt[i] > 0) begin
                fcnt[i] = fcnt[i] - 1;
                bpos[i] = (bpos[i] + 1) % blen[i];
            end
        end
        #1;
    endtask

    task automatic clear_fifo();
        for (int i = 0; i < 4; i++) begin
            fcnt[i] = 0; blen[i] = 1; bpos[i] = 0; fdest[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_fifo();
        tb_rst = 1'b1;
        begin_cycle();
        end_cycle();
        tb_rst = 1'b0;
    endtask

    initial begin : main
        int pops0, pops2, pops3, pops1;
        int ready_pat[5];

        for (int m = 0; m < 2; m++) begin
            mb[m] = 0; mo[m] = 0; mp[m] = 0; exp_pop_s[m] = 0;
        end
        clear_fifo();
        follow   = 0;
        tb_rst   = 1'b0;
        tb_ready = 1'b1;
        applyStimulus(1'b1, 4'h0, 8'h00, 4'hF, 1'b1);
        @(posedge ACLK);
        #1;

        // Reset held two cycles, then single-beat round-robin rotation 0,1,2,3,0
        vecs[0]  = mk(1, 4'h0, 8'h00, 4'hF, 1, 0, 2'd0, 4'h0, 4'h0);
        vecs[1]  = mk(1, 4'h0, 8'h00, 4'hF, 1, 0, 2'd0, 4'h0, 4'h0);
        vecs[2]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 0, 2'd0, 4'h0, 4'h0);
        vecs[3]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 1, 2'd0, 4'h1, 4'h1);
        vecs[4]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 0, 2'd0, 4'h0, 4'h0);
        vecs[5]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 1, 2'd1, 4'h2, 4'h2);
        vecs[6]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 0, 2'd1, 4'h0, 4'h0);
        vecs[7]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 1, 2'd2, 4'h4, 4'h4);
        vecs[8]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 0, 2'd2, 4'h0, 4'h0);
        vecs[9]  = mk(0, 4'h0, 8'h00, 4'hF, 1, 1, 2'd3, 4'h8, 4'h8);
        vecs[10] = mk(0, 4'h0, 8'h00, 4'hF, 1, 0, 2'd3, 4'h0, 4'h0);
        vecs[11] = mk(0, 4'h0, 8'h00, 4'hF, 1, 1, 2'd0, 4'h1, 4'h1);

        $display("[TB] vector table");
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].empty, vecs[v].dest, vecs[v].last, vecs[v].ready);
            #1;
            checkOutput("vec_valid",  int'(rr_valid),  int'(vecs[v].valid));
            checkOutput("vec_master", int'(rr_num),    int'(vecs[v].num));
            checkOutput("vec_onehot", int'(rr_onehot), int'(vecs[v].onehot));
            checkOutput("vec_pop",    int'(rr_pop),    int'(vecs[v].pop));
            check_models();
            end_cycle();
        end

        // Burst hold: master 2 owns a 4-beat burst while master 0 waits
        $display("[TB] burst hold");
        do_reset();
        fcnt[2] = 4; blen[2] = 4; tb_ready = 1'b1;
        begin_cycle(); end_cycle();
        fcnt[0] = 1; blen[0] = 1;
        ready_pat = '{1, 0, 1, 1, 1};
        pops0 = 0; pops2 = 0;
        for (int k = 0; k < 5; k++) begin
            tb_ready = ready_pat[k][0];
            begin_cycle();
            pops2 += int'(rr_pop[2]);
            pops0 += int'(rr_pop[0]);
            end_cycle();
        end
        checkOutput("hold_pops_m2", pops2, 4);
        checkOutput("hold_pops_m0", pops0, 0);
        tb_ready = 1'b1;
        begin_cycle();
        checkOutput("hold_gap_valid", int'(rr_valid), 0);
        end_cycle();
        begin_cycle();
        checkOutput("hold_next_valid",  int'(rr_valid), 1);
        checkOutput("hold_next_master", int'(rr_num),   0);
        end_cycle();

        // Destination filter: master 1 targets slave 3, master 3 targets us
        $display("[TB] destination filter");
        do_reset();
        fcnt[1] = 3; fdest[1] = 3;
        fcnt[3] = 2; fdest[3] = 0;
        pops1 = 0; pops3 = 0;
        for (int k = 0; k < 6; k++) begin
            begin_cycle();
            pops1 += int'(rr_pop[1]);
            pops3 += int'(rr_pop[3]);
            end_cycle();
        end
        checkOutput("filter_pops_m1", pops1, 0);
        checkOutput("filter_pops_m3", pops3, 2);

        // Fixed priority: masters 1 and 3 both keep requesting
        $display("[TB] fixed priority");
        do_reset();
        follow = 1;
        fcnt[1] = 20; fcnt[3] = 20;
        pops3 = 0;
        for (int k = 0; k < 12; k++) begin
            begin_cycle();
            if (fx_valid) checkOutput("fixed_winner", int'(fx_num), 1);
            pops3 += int'(fx_pop[3]);
            end_cycle();
        end
        checkOutput("fixed_pops_m3", pops3, 0);
        follow = 0;

        // Stalled burst followed by reset; pointer must return to 0
        $display("[TB] mid-burst stall and reset");
        do_reset();
        fcnt[1] = 1;
        begin_cycle(); end_cycle();
        fcnt[0] = 2; blen[0] = 4; bpos[0] = 0;
        for (int k = 0; k < 4; k++) begin
            begin_cycle(); end_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            begin_cycle();
            checkOutput("stall_valid",  int'(rr_valid), 1);
            checkOutput("stall_master", int'(rr_num),   0);
            checkOutput("stall_pop",    int'(rr_pop),   0);
            end_cycle();
        end
        tb_rst = 1'b1;
        begin_cycle(); end_cycle();
        tb_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fcnt[i] = 1; blen[i] = 1; bpos[i] = 0; fdest[i] = 0;
        end
        begin_cycle();
        checkOutput("reset_drop_valid", int'(rr_valid), 0);
        end_cycle();
        begin_cycle();
        checkOutput("reset_ptr_valid",  int'(rr_valid), 1);
        checkOutput("reset_ptr_master", int'(rr_num),   0);
        end_cycle();

        // Randomised traffic against the reference model
        $display("[TB] random traffic");
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (fcnt[i] == 0 && $urandom_range(0, 3) == 0) begin
                    fcnt[i]  = int'($urandom_range(1, 6));
                    blen[i]  = int'($urandom_range(1, 4));
                    bpos[i]  = 0;
                    fdest[i] = int'($urandom_range(0, 3));
                end
            end
            tb_ready = ($urandom_range(0, 3) != 0);
            tb_rst   = ($urandom_range(0, 63) == 0);
            follow   = (c < 300) ? 0 : 1;
            begin_cycle();
            end_cycle();
        end
        tb_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/xbar_slave_arbiter.md
# xbar_slave_arbiter

Per-slave-port arbiter for the AXI crossbar. It selects one master whose request FIFO head is addressed to this slave and holds that grant for the whole burst, until the last beat is popped. It then rotates priority past the winner (round-robin mode) or keeps a static order (fixed mode). It instantiates once per slave, between the master request FIFOs and the slave-side channel mux, and adds per-beat pop control that the earlier combinational arbiter lacked.

## Interface
- `MASTERS`, default 4: number of master request FIFOs; must be ≥ 1.
- `SLAVES`, default 4: number of slaves addressable by `master_slave_dest`.
- `SLAVE_ID`, default 0: this port's slave number.
- `RR_MODE`, default 1: 1 selects round-robin; 0 selects fixed priority, where master 0 is highest.
- `ACLK` in, 1: the single clock; all logic is on the rising edge.
- `ARESET` in, 1: synchronous reset, active-high.
- `master_fifo_empty` in, `MASTERS`: per-master FIFO empty flag.
- `master_slave_dest` in, `MASTERS` × `DW`: destination of each FIFO head beat. `DW = max(1, $clog2(SLAVES))`.
- `master_beat_last` in, `MASTERS`: the head beat is the last beat of its burst.
- `slave_ready` in, 1: the downstream slave channel accepts a beat this cycle.
- `grant_valid` out, 1: a master currently owns this slave.
- `grant_master_number` out, `MW`: index of the owning master. `MW = max(1, $clog2(MASTERS))`.
- `grant_onehot` out, `MASTERS`: one-hot form of the grant; all zeros when `grant_valid` is 0.
- `master_pop` out, `MASTERS`: pop strobe for each master FIFO; at most one bit is set per cycle.

## Operation
- Request vector: `req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == SLAVE_ID)`.
- State machine with two states, `IDLE` and `BUSY`.
- In `IDLE`:
  - If `req` is nonzero, pick a winner and move to `BUSY` on the next edge.
  - The winner is loaded into the `owner` register.
  - If `req` is zero, stay in `IDLE`.
- Winner selection:
  - `RR_MODE=1`: the first set `req` bit searching upward from `rr_ptr`, wrapping from `MASTERS-1` to 0.
  - `RR_MODE=0`: the lowest set index; `rr_ptr` is ignored.
- In `BUSY`:
  - `master_pop[owner] = slave_ready & ~master_fifo_empty[owner]`.
  - `master_slave_dest` is not re-checked; ownership is burst-level.
  - An empty FIFO mid-burst gives no pop and keeps ownership indefinitely.
- Release: a pop with `master_beat_last[owner]=1` sends the state to `IDLE` on the next edge. In round-robin mode, `rr_ptr` becomes `(owner+1) mod MASTERS` at that edge.
- Outputs are driven only from state and registers, except `master_pop`, which also depends combinationally on `slave_ready` and `master_fifo_empty`.
- With `MASTERS=1`: `rr_ptr` stays 0 and `owner` is always 0.

## Timing
- Reset values: state `IDLE`, `rr_ptr=0`, `owner=0`, `grant_valid=0`, `grant_master_number=0`, `grant_onehot=0`, `master_pop=0`.
- Request to grant: a `req` first visible in cycle N gives `grant_valid=1` in cycle N+1. The first pop can occur in cycle N+1.
- Release to next grant: a last-beat pop in cycle M gives `grant_valid=0` in M+1 (`IDLE`, arbitration). A new grant is valid in M+2. This fixed one-cycle bubble between bursts is intended.
- Simultaneous requests arbitrate in a single cycle; losing requests stay pending with no pop.
- A single-beat burst (last beat on the first pop) holds the grant for exactly one cycle if `slave_ready=1`.
- Reset asserted mid-burst: the grant drops on the next edge and `rr_ptr` returns to 0. FIFO contents are not the arbiter's concern.
- No combinational path from `master_fifo_empty` or `master_slave_dest` to `grant_*`.

## Structure
- Shared package `xbar_pkg`:
  - `arb_state_e` enum (`IDLE`, `BUSY`).
  - Function `clog2_min1(n)` used for `MW` and `DW`.
- Sub-module `rr_priority_picker`: parameter `N`. Inputs `req[N]`, `ptr[MW]`, `rr_en`. Outputs `any`, `idx[MW]`. Purely combinational first-set search with wrap.
- The top level holds the state machine, `owner`, `rr_ptr` and pop/grant decode.

## Test plan
- Reset: `ARESET=1` for 2 cycles with all FIFOs non-empty to slave 0 → all outputs 0 throughout; `grant_master_number=0` one cycle after release.
- Round-robin fairness (`MASTERS=4`, all four request `SLAVE_ID`, single-beat bursts, `slave_ready=1`) → grant order 0,1,2,3,0, each grant separated by one idle cycle.
- Burst hold: master 2 has a 4-beat burst, master 0 also requests, `slave_ready` toggles 1,0,1,1,1 → exactly 4 pops to master 2 with no pops to master 0; release follows the last beat; master 0 is granted 2 cycles after the last pop.
- Destination filter: master 1 requests slave 3 and master 3 requests `SLAVE_ID=0` → only master 3 is granted; master 1 never sees a pop.
- Fixed mode (`RR_MODE=0`): masters 1 and 3 request continuously with single beats → master 1 wins every arbitration.
- Mid-burst empty and reset: master 0 goes empty after beat 2 of 4 → grant holds for 10 cycles with no pops. Then `ARESET=1` for 1 cycle → `grant_valid=0` on the next cycle and `rr_ptr=0`.
